mem_ctrl: RTL

Byte-serial memory controller that sits directly downstream of the MEM stage and the instruction-fetch stage. It turns their word-level load/store/fetch requests into byte transactions on the single 8-bit RAM port, and reassembles and sign/zero-extends load data. It returns a one-cycle ready pulse per completed request. The MEM request has priority over the fetch request.

---
 rtl/mem_ctrl.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Purpose  : Byte-serial memory controller between the MEM / instruction-
//             fetch stages and a single 8-bit RAM port. Word-level load,
//             store and fetch requests are split into byte transactions.
//             Load data is reassembled little-endian and sign/zero-extended.
//             Each completed request returns a one-cycle ready pulse.
//             Priority: mem_write > mem_read > if_read.
//  Ports    : clk, rst_n (async, active-low), rdy (global enable)
//             MEM   : mem_read, mem_write, mem_addr, mem_data_i, mem_length,
//                     mem_signed -> mem_ready, mem_data_o
//             Fetch : if_read, if_addr -> if_ready, if_data
//             RAM   : ram_din -> ram_dout, ram_a, ram_wr
//             IO    : io_buffer_full
//  Config   : define MEM_CTRL_IO_STALL_EN to hold off stores to the IO region
//             (addr[17:16] == IO_BASE_HI) while io_buffer_full is high.
//  Revision : 1.0  initial release
// ============================================================================
module mem_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter logic [1:0]  IO_BASE_HI = 2'b11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data_i,
  input  logic [2:0]        mem_length,
  input  logic              mem_signed,
  output logic              mem_ready,
  output logic [31:0]       mem_data_o,
  input  logic              if_read,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_data,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;            // byte counter
  logic [2:0]        n_q, n_d;            // byte count: 1, 2 or 4
  logic [ADDR_W-1:0] base_q, base_d;
  logic              sign_q, sign_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              from_mem_q, from_mem_d; // 1 = MEM requester, 0 = fetch
  logic              mem_ready_q, mem_ready_d;
  logic              if_ready_q, if_ready_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic [31:0]       if_data_q, if_data_d;
  // The RAM keeps returning data for the held address while rdy is low, so
  // the byte that was valid on the first stalled edge is parked here and
  // consumed on the first enabled edge.
  logic [7:0]        din_hold_q, din_hold_d;
  logic              din_held_q, din_held_d;

  logic [2:0]        mem_n;
  logic              io_block;
  logic              take_write;
  logic              req_live;
  logic [7:0]        din_eff;

  assign mem_n = (mem_length == 3'd1) ? 3'd1 :
                 (mem_length == 3'd2) ? 3'd2 : 3'd4;

`ifdef MEM_CTRL_IO_STALL_EN
  assign io_block = mem_write && (mem_addr[17:16] == IO_BASE_HI) && io_buffer_full;
`else
  logic unused_io_cfg;
  assign io_block      = 1'b0;
  assign unused_io_cfg = ^{io_buffer_full, IO_BASE_HI};
`endif

  assign take_write = mem_write && !io_block;
  assign req_live   = from_mem_q ? mem_read : if_read;
  assign din_eff    = din_held_q ? din_hold_q : ram_din;

  function automatic logic [31:0] extend(input logic [31:0] w,
                                         input logic [2:0]  n,
                                         input logic        s);
    logic [31:0] r;
    r = w;
    if (n == 3'd1) begin
      r = {{24{s & w[7]}}, w[7:0]};
    end else if (n == 3'd2) begin
      r = {{16{s & w[15]}}, w[15:0]};
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    base_d      = base_q;
    sign_d      = sign_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    from_mem_d  = from_mem_q;
    mem_ready_d = mem_ready_q;
    if_ready_d  = if_ready_q;
    mem_data_d  = mem_data_q;
    if_data_d   = if_data_q;
    din_hold_d  = din_hold_q;
    din_held_d  = din_held_q;

    if (rdy) begin
      din_held_d  = 1'b0;
      mem_ready_d = 1'b0;
      if_ready_d  = 1'b0;
      case (state_q)
        IDLE: begin
          k_d = 3'd0;
          if (take_write) begin
            state_d    = WRITE;
            base_d     = mem_addr;
            n_d        = mem_n;
            sign_d     = mem_signed;
            wdata_d    = mem_data_i;
            from_mem_d = 1'b1;
          end else if (mem_read) begin
            state_d    = READ;
            base_d     = mem_addr;
            n_d        = mem_n;
            sign_d     = mem_signed;
            from_mem_d = 1'b1;
          end else if (if_read) begin
            state_d    = READ;
            base_d     = if_addr;
            n_d        = 3'd4;
            sign_d     = 1'b0;
            from_mem_d = 1'b0;
          end
        end
        READ: begin
          if (!req_live) begin
            state_d = IDLE;
            k_d     = 3'd0;
          end else begin
            // Data for address base+k-1 arrives while base+k is driven.
            case (k_q)
              3'd1:    rdata_d[7:0]   = din_eff;
              3'd2:    rdata_d[15:8]  = din_eff;
              3'd3:    rdata_d[23:16] = din_eff;
              3'd4:    rdata_d[31:24] = din_eff;
              default: ;
            endcase
            if (k_q == n_q) begin
              state_d = DONE;
              if (from_mem_q) begin
                mem_ready_d = 1'b1;
                mem_data_d  = extend(rdata_d, n_q, sign_q);
              end else begin
                if_ready_d = 1'b1;
                if_data_d  = rdata_d;
              end
            end else begin
              k_d = k_q + 3'd1;
            end
          end
        end
        WRITE: begin
          if (k_q == n_q - 3'd1) begin
            state_d     = DONE;
            mem_ready_d = 1'b1;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
        DONE: begin
          state_d = IDLE;
          k_d     = 3'd0;
        end
        default: state_d = IDLE;
      endcase
    end else if (!din_held_q) begin
      din_held_d = 1'b1;
      din_hold_d = ram_din;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      n_q         <= 3'd4;
      base_q      <= '0;
      sign_q      <= 1'b0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      from_mem_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_data_q  <= 32'd0;
      if_data_q   <= 32'd0;
      din_hold_q  <= 8'd0;
      din_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      base_q      <= base_d;
      sign_q      <= sign_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      from_mem_q  <= from_mem_d;
      mem_ready_q <= mem_ready_d;
      if_ready_q  <= if_ready_d;
      mem_data_q  <= mem_data_d;
      if_data_q   <= if_data_d;
      din_hold_q  <= din_hold_d;
      din_held_q  <= din_held_d;
    end
  end

  // --------------------------------------------------------------------------
  // RAM port: decoded from registered state so reset clears it immediately
  // and a stall (counter frozen) keeps ram_a steady.
  // --------------------------------------------------------------------------
  always_comb begin
    ram_a    = '0;
    ram_dout = 8'd0;
    ram_wr   = 1'b0;
    if (state_q == WRITE) begin
      ram_a    = base_q + ADDR_W'(k_q);
      ram_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
      ram_wr   = rdy;
    end else if ((state_q == READ) && (k_q < n_q)) begin
      ram_a = base_q + ADDR_W'(k_q);
    end
  end

  assign mem_ready  = mem_ready_q;
  assign if_ready   = if_ready_q;
  assign mem_data_o = mem_data_q;
  assign if_data    = if_data_q;

endmodule
`default_nettype wire
